pcpi_aes32_copro: RTL



---
 rtl/pcpi_aes32_copro.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pcpi_aes32_copro.sv
// pcpi_aes32_copro: PCPI coprocessor for the RISC-V scalar AES round instructions (aes32esi/esmi).
// Define AES_DECRYPT_EN to also claim aes32dsi/dsmi and build the inverse S-box and InvMixColumn multipliers.
module pcpi_aes32_copro #(
  parameter int FAST = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_DECRYPT_EN
  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rol_bytes(input logic [31:0] u, input logic [1:0] bs);
    logic [31:0] r;
    case (bs)
      2'd0:    r = u;
      2'd1:    r = {u[23:0], u[31:24]};
      2'd2:    r = {u[15:0], u[31:16]};
      2'd3:    r = {u[7:0], u[31:8]};
      default: r = u;
    endcase
    return r;
  endfunction

  state_t      state_r, next_s;
  logic        match_s, dec_s, mix_s, accept_s;
  logic        hold_r, dec_r, mix_r;
  logic [1:0]  bs_r;
  logic [7:0]  byte_sel_s, byte_r, sub_r, sbox_s, x_s, x2_s;
  logic [31:0] rs1_r, u_s;
  logic        unused_insn_s;
`ifdef AES_DECRYPT_EN
  logic [7:0]  x4_s, x8_s;
`endif

  // register-number fields are irrelevant to the coprocessor
  assign unused_insn_s = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // instruction decode: claim only the AES round encodings
  always_comb begin
    match_s = 1'b0;
    dec_s   = 1'b0;
    mix_s   = 1'b0;
    if ((pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[14:12] == 3'b000)) begin
      case (pcpi_insn[29:25])
        5'b10001: match_s = 1'b1;
        5'b10011: begin match_s = 1'b1; mix_s = 1'b1; end
`ifdef AES_DECRYPT_EN
        5'b10101: begin match_s = 1'b1; dec_s = 1'b1; end
        5'b10111: begin match_s = 1'b1; dec_s = 1'b1; mix_s = 1'b1; end
`endif
        default:  match_s = 1'b0;
      endcase
    end else begin
      match_s = 1'b0;
    end
  end

  // select the rs2 byte addressed by bs
  always_comb begin
    case (pcpi_insn[31:30])
      2'd0:    byte_sel_s = pcpi_rs2[7:0];
      2'd1:    byte_sel_s = pcpi_rs2[15:8];
      2'd2:    byte_sel_s = pcpi_rs2[23:16];
      2'd3:    byte_sel_s = pcpi_rs2[31:24];
      default: byte_sel_s = pcpi_rs2[7:0];
    endcase
  end

  // shared S-box lookup, direction from the latched opcode
  always_comb begin
`ifdef AES_DECRYPT_EN
    if (dec_r) begin
      sbox_s = SBOX_INV[byte_r];
    end else begin
      sbox_s = SBOX_FWD[byte_r];
    end
`else
    sbox_s = SBOX_FWD[byte_r];
`endif
  end

  // FAST folds the lookup into the mix cycle; otherwise use the registered S-box output
  assign x_s = (FAST != 32'sd0) ? sbox_s : sub_r;

  // column mix value u in GF(2^8)
  always_comb begin
    x2_s = xtime(x_s);
`ifdef AES_DECRYPT_EN
    x4_s = xtime(x2_s);
    x8_s = xtime(x4_s);
`endif
    u_s = {24'h000000, x_s};
    case ({dec_r, mix_r})
      2'b00:   u_s = {24'h000000, x_s};
      2'b01:   u_s = {x2_s ^ x_s, x_s, x_s, x2_s};
`ifdef AES_DECRYPT_EN
      2'b10:   u_s = {24'h000000, x_s};
      2'b11:   u_s = {x8_s ^ x2_s ^ x_s, x8_s ^ x4_s ^ x_s, x8_s ^ x_s, x8_s ^ x4_s ^ x2_s};
`endif
      default: u_s = {24'h000000, x_s};
    endcase
  end

  // next-state logic; the cycle after DONE ignores pcpi_valid
  always_comb begin
    next_s   = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pcpi_valid && match_s && !hold_r) begin
          accept_s = 1'b1;
          if (FAST != 32'sd0) begin
            next_s = ST_MIX;
          end else begin
            next_s = ST_SUB;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_SUB: begin
        if (pcpi_valid) begin
          next_s = ST_MIX;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_MIX: begin
        if (pcpi_valid) begin
          next_s = ST_DONE;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // state register and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      hold_r     <= 1'b0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
    end else begin
      state_r    <= next_s;
      hold_r     <= (state_r == ST_DONE);
      pcpi_wait  <= (next_s == ST_SUB) || (next_s == ST_MIX);
      pcpi_ready <= (next_s == ST_DONE);
      pcpi_wr    <= (next_s == ST_DONE);
    end
  end

  // operand latch, S-box pipeline register and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_r   <= 32'h00000000;
      bs_r    <= 2'd0;
      dec_r   <= 1'b0;
      mix_r   <= 1'b0;
      byte_r  <= 8'h00;
      sub_r   <= 8'h00;
      pcpi_rd <= 32'h00000000;
    end else begin
      if (accept_s) begin
        rs1_r  <= pcpi_rs1;
        bs_r   <= pcpi_insn[31:30];
        dec_r  <= dec_s;
        mix_r  <= mix_s;
        byte_r <= byte_sel_s;
      end
      if (state_r == ST_SUB) begin
        sub_r <= sbox_s;
      end
      if ((state_r == ST_MIX) && pcpi_valid) begin
        pcpi_rd <= rs1_r ^ rol_bytes(u_s, bs_r);
      end
    end
  end

endmodule
